// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default line parameters
// (also used by the transmitter).
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 434;   // 50 MHz / 115200
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Host-side port of the UART receiver: received word, status flags and consume ack.
interface uart_receiver_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 framing_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, framing_err, overrun, busy,
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_valid, framing_err, overrun, busy,
    output rx_ack
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; reset value chosen per bit
// so idle-high lines do not glitch low on reset release.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          meta_reg <= RESET_VAL[gi];
          sync_reg <= RESET_VAL[gi];
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
        end
      end

      assign q[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start-bit validation, mid-bit sampling of LSB-first data, stop-bit
// check, and a level-valid/ack host handshake with framing and overrun flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  uart_receiver_if.master host
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  rx_state_t            state_reg, state_next;
  logic [CW-1:0]        cnt_reg;
  logic [IW-1:0]        idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg, framing_err_reg, overrun_reg, busy_reg;
  logic                 rx_s;
  logic                 half_hit, full_hit;
  logic                 bit_sample, stop_good, stop_bad;

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  assign half_hit = (cnt_reg == CNT_HALF);
  assign full_hit = (cnt_reg == CNT_FULL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (!rx_s) state_next = START;
      START:     if (half_hit) state_next = rx_s ? IDLE : DATA;
      DATA:      if (full_hit && (idx_reg == IDX_LAST)) state_next = STOP;
      STOP:      if (full_hit) state_next = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    bit_sample = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state_reg)
      DATA: bit_sample = full_hit;
      STOP: begin
        stop_good = full_hit &&  rx_s;
        stop_bad  = full_hit && !rx_s;
      end
      default: ;
    endcase
  end

  // The bit counter also wraps at each data sample so DATA can run back-to-back bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      if ((state_next != state_reg) || full_hit) cnt_reg <= '0;
      else                                       cnt_reg <= cnt_reg + 1'b1;

      if (state_reg != DATA) idx_reg <= '0;
      else if (bit_sample)   idx_reg <= idx_reg + 1'b1;

      if (bit_sample) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
    end
  end

  // An unacked word is never overwritten; an ack landing on the completion cycle frees the slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      framing_err_reg <= 1'b0;
      overrun_reg     <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      framing_err_reg <= stop_bad;
      busy_reg        <= (state_next != IDLE);
      if (stop_good) begin
        if (rx_valid_reg && !host.rx_ack) begin
          overrun_reg <= 1'b1;
        end else begin
          rx_data_reg  <= shift_reg;
          rx_valid_reg <= 1'b1;
          overrun_reg  <= 1'b0;
        end
      end else if (rx_valid_reg && host.rx_ack) begin
        rx_valid_reg <= 1'b0;
        overrun_reg  <= 1'b0;
      end
    end
  end

  assign host.rx_data     = rx_data_reg;
  assign host.rx_valid    = rx_valid_reg;
  assign host.framing_err = framing_err_reg;
  assign host.overrun     = overrun_reg;
  assign host.busy        = busy_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of good frames plus hand-written sequences
// for latency, glitch, break, overrun, reset abort and baud tolerance.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPB       = 16;
  localparam int CPB2      = 10;
  localparam int DB        = 8;
  localparam int VALID_LAT = 2 + CPB / 2 + (DB + 1) * CPB;  // 154 edges after N0

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic rx1     = 1'b1;
  logic rx2     = 1'b1;

  uart_receiver_if #(.DATA_BITS(DB)) h1 ();
  uart_receiver_if #(.DATA_BITS(DB)) h2 ();

  always #5 clk = ~clk;

  uart_receiver #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx1), .host(h1)
  );

  uart_receiver #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB2)) dut_baud (
    .clk(clk), .reset_n(reset_n), .rx(rx2), .host(h2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ferr1_cnt = 0;
  int ferr2_cnt = 0;
  int ovr2_cnt  = 0;

  always @(negedge clk) begin
    if (h1.framing_err === 1'b1) ferr1_cnt++;
    if (h2.framing_err === 1'b1) ferr2_cnt++;
    if (h2.overrun === 1'b1) ovr2_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  // Called right after a falling edge; returns on the falling edge ending the stop period.
  task automatic send1(input logic [7:0] d, input int stop_low_bits);
    rx1 = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx1 = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (stop_low_bits > 0) begin
      rx1 = 1'b0;
      repeat (stop_low_bits * CPB) @(negedge clk);
    end else begin
      rx1 = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  // Free-running transmitter model with its own bit period, unrelated to clk phase.
  task automatic send2(input logic [7:0] d, input int bit_t);
    rx2 = 1'b0;
    #(bit_t);
    for (int i = 0; i < DB; i++) begin
      rx2 = d[i];
      #(bit_t);
    end
    rx2 = 1'b1;
    #(bit_t);
  endtask

  task automatic ack1();
    h1.rx_ack = 1'b1;
    @(negedge clk);
    h1.rx_ack = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int ferr0;
    int wait_n;
    logic [7:0] wd;
    int bit_t;

    vecs[0] = '{data: 8'h00, exp_data: 8'h00, exp_valid: 1'b1, exp_ferr: 0};
    vecs[1] = '{data: 8'hFF, exp_data: 8'hFF, exp_valid: 1'b1, exp_ferr: 0};
    vecs[2] = '{data: 8'h01, exp_data: 8'h01, exp_valid: 1'b1, exp_ferr: 0};
    vecs[3] = '{data: 8'h80, exp_data: 8'h80, exp_valid: 1'b1, exp_ferr: 0};
    vecs[4] = '{data: 8'h5A, exp_data: 8'h5A, exp_valid: 1'b1, exp_ferr: 0};
    vecs[5] = '{data: 8'hC3, exp_data: 8'hC3, exp_valid: 1'b1, exp_ferr: 0};

    h1.rx_ack = 1'b0;
    h2.rx_ack = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rx_data",     h1.rx_data,     0);
    check("rst_rx_valid",    h1.rx_valid,    0);
    check("rst_framing_err", h1.framing_err, 0);
    check("rst_overrun",     h1.overrun,     0);
    check("rst_busy",        h1.busy,        0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xA5 with exact valid latency; monitor counts falling edges from the start edge
    ferr0 = ferr1_cnt;
    fork
      send1(8'hA5, 0);
      begin
        lat = 0;
        while (h1.rx_valid !== 1'b1 && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("a5_latency",  lat, VALID_LAT + 1);
    check("a5_data",     h1.rx_data, 8'hA5);
    check("a5_ferr",     ferr1_cnt - ferr0, 0);
    check("a5_overrun",  h1.overrun, 0);
    ack1();
    check("a5_ack_valid", h1.rx_valid, 0);

    // Table of good frames
    for (int v = 0; v < 6; v++) begin
      ferr0 = ferr1_cnt;
      send1(vecs[v].data, 0);
      check($sformatf("vec%0d_valid", v),   h1.rx_valid, vecs[v].exp_valid);
      check($sformatf("vec%0d_data", v),    h1.rx_data,  vecs[v].exp_data);
      check($sformatf("vec%0d_overrun", v), h1.overrun,  0);
      check($sformatf("vec%0d_ferr", v),    ferr1_cnt - ferr0, vecs[v].exp_ferr);
      ack1();
      check($sformatf("vec%0d_ack", v),     h1.rx_valid, 0);
    end

    // Start glitch: 4 low cycles is rejected at the half-bit check
    ferr0 = ferr1_cnt;
    rx1 = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_hi", h1.busy, 1);
    rx1 = 1'b1;
    repeat (16) @(negedge clk);
    check("glitch_busy_lo", h1.busy, 0);
    check("glitch_valid",   h1.rx_valid, 0);
    check("glitch_data",    h1.rx_data, 8'hC3);
    check("glitch_ferr",    ferr1_cnt - ferr0, 0);
    send1(8'h3C, 0);
    check("post_glitch_valid", h1.rx_valid, 1);
    check("post_glitch_data",  h1.rx_data, 8'h3C);
    ack1();

    // Stop bit held low for three bit periods (break)
    ferr0 = ferr1_cnt;
    send1(8'h81, 3);
    check("brk_ferr_pulses", ferr1_cnt - ferr0, 1);
    check("brk_valid",       h1.rx_valid, 0);
    check("brk_data",        h1.rx_data, 8'h3C);
    check("brk_busy_held",   h1.busy, 1);
    rx1 = 1'b1;
    repeat (4) @(negedge clk);
    check("brk_busy_release", h1.busy, 0);
    ferr0 = ferr1_cnt;
    send1(8'h55, 0);
    check("post_brk_valid", h1.rx_valid, 1);
    check("post_brk_data",  h1.rx_data, 8'h55);
    check("post_brk_ferr",  ferr1_cnt - ferr0, 0);
    ack1();

    // Overrun: two frames back-to-back without ack
    send1(8'h11, 0);
    send1(8'h22, 0);
    check("ovr_data",    h1.rx_data, 8'h11);
    check("ovr_valid",   h1.rx_valid, 1);
    check("ovr_flag",    h1.overrun, 1);
    ack1();
    check("ovr_ack_valid", h1.rx_valid, 0);
    check("ovr_ack_flag",  h1.overrun, 0);

    // Ack coincident with the second completion edge
    send1(8'h11, 0);
    fork
      send1(8'h22, 0);
      begin
        repeat (VALID_LAT) @(negedge clk);
        h1.rx_ack = 1'b1;
        @(negedge clk);
        h1.rx_ack = 1'b0;
      end
    join
    check("coinc_data",    h1.rx_data, 8'h22);
    check("coinc_valid",   h1.rx_valid, 1);
    check("coinc_overrun", h1.overrun, 0);
    ack1();

    // Asynchronous reset during data bit 4 of 0xFF, with a pending word to wipe
    send1(8'h5A, 0);
    check("pre_rst_valid", h1.rx_valid, 1);
    fork
      send1(8'hFF, 0);
      begin
        repeat (5 * CPB + CPB / 2 + 2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_data",    h1.rx_data, 0);
        check("midrst_valid",   h1.rx_valid, 0);
        check("midrst_ferr",    h1.framing_err, 0);
        check("midrst_overrun", h1.overrun, 0);
        check("midrst_busy",    h1.busy, 0);
      end
    join
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", h1.busy, 0);
    send1(8'h0F, 0);
    check("post_rst_valid", h1.rx_valid, 1);
    check("post_rst_data",  h1.rx_data, 8'h0F);
    ack1();

    // 256 random words at CLKS_PER_BIT=10 with -3% / 0 / +3% transmitter baud
    for (int w = 0; w < 256; w++) begin
      wd    = 8'($urandom);
      bit_t = (w % 3 == 0) ? 97 : ((w % 3 == 1) ? 103 : 100);
      send2(wd, bit_t);
      @(negedge clk);
      wait_n = 0;
      while (h2.rx_valid !== 1'b1 && wait_n < 40) begin
        @(negedge clk);
        wait_n++;
      end
      check($sformatf("baud_w%0d_t%0d", w, bit_t), {h2.rx_valid, h2.rx_data}, {1'b1, wd});
      h2.rx_ack = 1'b1;
      @(negedge clk);
      h2.rx_ack = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    check("baud_ferr_count",    ferr2_cnt, 0);
    check("baud_overrun_count", ovr2_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver, the receive-side counterpart to the team's transmitter path. It synchronises the asynchronous `rx` line and detects and validates the start bit. It samples each data bit at mid-bit (LSB first) and checks the stop bit, then presents the received word to the host through a level-valid/ack handshake with framing and overrun flags.

## Interface
- `DATA_BITS`, 8: data bits per frame (5–9).
- `CLKS_PER_BIT`, 434: clk cycles per bit period (50 MHz / 115200); legal ≥ 4, even values required.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, asynchronous to clk, idle high.
- `rx_ack`  in  1  host consumed `rx_data`; clears `rx_valid` and `overrun`.
- `rx_data`  out  DATA_BITS  last good word, LSB = first received bit.
- `rx_valid`  out  1  level: `rx_data` holds an unconsumed word.
- `framing_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  sticky: a good frame completed while `rx_valid` was already 1.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Reset values: `rx_data`=0, `rx_valid`=0, `framing_err`=0, `overrun`=0, `busy`=0. The state is IDLE, the counters are 0 and both sync flops are 1.
- `rx` passes through a 2-flop synchroniser; the FSM uses only the synchronised `rx_s`.
- Bit counter `cnt` (width clog2(CLKS_PER_BIT)) is cleared on every state entry and increments every cycle otherwise. Bit index `idx` counts 0..DATA_BITS-1.
- States:
  - IDLE: when `rx_s`=0, go to START.
  - START: when `cnt`=CLKS_PER_BIT/2−1, sample `rx_s`. A 0 goes to DATA. A 1 is a glitch and returns to IDLE with no flags.
  - DATA: when `cnt`=CLKS_PER_BIT−1, shift `rx_s` into the MSB of the shift register (right shift) and increment `idx`. After the DATA_BITS-th sample, go to STOP.
  - STOP: when `cnt`=CLKS_PER_BIT−1, sample `rx_s`.
    - 1: load `rx_data` and go to IDLE. If `rx_valid`=1 and `rx_ack`=0 that cycle, set `overrun` and leave `rx_data` unchanged (old word preserved). Otherwise set `rx_valid`.
    - 0: pulse `framing_err`, leave `rx_data`/`rx_valid` unchanged and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This blocks a break condition from retriggering START.
- `rx_ack` while `rx_valid`=1 clears `rx_valid` and `overrun` at the next edge. `rx_ack` while `rx_valid`=0 has no effect.
- A good stop and `rx_ack` in the same cycle: the new word loads, `rx_valid` stays 1 and no overrun is raised.
- Asynchronous reset mid-frame aborts the frame immediately; the partial word is discarded.

## Timing
- Let N0 be the first edge at which the sync flop 1 captures `rx`=0 (start edge).
  - START is entered at N0+2.
  - DATA is entered at N0+2+CLKS_PER_BIT/2.
  - Data bit k is sampled at N0+2+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
- `rx_valid`/`rx_data` are updated at edge N0+2+CLKS_PER_BIT/2+(DATA_BITS+1)·CLKS_PER_BIT. `framing_err` is high for the cycle after that same edge.
- All sample points sit at mid-bit relative to the synchronised edge. Tolerated baud mismatch is ±(50%/(DATA_BITS+1.5)) minus synchroniser skew.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge arriving immediately after the stop bit is caught with no lost cycles.
- All outputs are registered; there are no combinational paths from `rx`/`rx_ack` to the outputs.

## Structure
- The shared package `uart_pkg` holds:
  - the FSM state encoding (IDLE, START, DATA, STOP, WAIT_HIGH), 3 bits;
  - the default `CLKS_PER_BIT`/`DATA_BITS` constants, shared with the transmitter.
- One sub-module: `sync_2ff` (parameterised reset value, here 1), reusable for other asynchronous inputs.
- The FSM, counters, shift register and output registers live in `uart_receiver`.

## Test plan
All scenarios use CLKS_PER_BIT=16 and DATA_BITS=8 unless noted.
- Send 0xA5 with correct framing → `rx_valid` rises exactly 154 cycles after N0, `rx_data`=0xA5, `framing_err`=0, `overrun`=0. `rx_ack` → `rx_valid`=0 next cycle.
- Start glitch: `rx` low for 4 cycles, then high → FSM returns to IDLE, `busy` drops and no output changes. A following 0x3C frame is received correctly.
- Send 0x81 with the stop bit driven low for 3 bit periods → `framing_err` pulses once, `rx_valid` stays 0 and no new frame starts until `rx` returns high. A following 0x55 is received.
- Send 0x11 then 0x22 back-to-back without ack → `rx_data`=0x11, `overrun`=1. `rx_ack` clears both `rx_valid` and `overrun`. A repeat with `rx_ack` asserted in the 0x22 completion cycle → `rx_data`=0x22, `rx_valid`=1, `overrun`=0.
- Assert `reset_n`=0 during data bit 4 of 0xFF → all outputs are at reset values immediately. After release, 0x0F is received correctly.
- `CLKS_PER_BIT`=10 with the transmitter model at ±3% baud error, 256 random words → all received correctly and no flags set.
